// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
//
// Instruction fetch unit for the MIPS-style cores. It holds the PC and reads
// one instruction word at a time from an external instruction memory using a
// req/ack handshake. Each fetched word is held in a one-entry output buffer and
// offered to decode with a valid/ready handshake, together with its PC and the
// split decode fields. Execute can redirect the fetch stream. When a redirect
// arrives while a memory read is still outstanding, the unit waits for that
// read's ack and throws the returned word away.
//
// Optional feature macro: IFU_BRANCH_EN
//   defined   : adds the br_taken/br_pc/br_offset ports and the relative branch
//               target adder.
//   undefined : only jmp_en can redirect.
//
// Parameters
//   ADDR_W    word-address width of the PC and of mem_addr
//   RESET_PC  PC value loaded on reset
//
// Ports
//   clk          clock; all state changes on the rising edge
//   Reset        synchronous active-high reset
//   mem_req      memory read request
//   mem_addr     word address of the request
//   mem_ack      one-cycle pulse; mem_rdata is valid in that cycle
//   mem_rdata    instruction word from memory
//   inst_valid   output buffer holds an instruction
//   inst_ready   decode accepts the buffered instruction
//   inst_code    buffered instruction word
//   pc_out       word address of inst_code
//   op_code, rs_addr, rt_addr, rd_addr, shamt, func, imm, address
//                decode fields taken from inst_code
//   jmp_en       jump redirect pulse
//   jmp_target   jump word address
//   br_taken     branch redirect              (IFU_BRANCH_EN only)
//   br_pc        word address of the branch   (IFU_BRANCH_EN only)
//   br_offset    signed word offset           (IFU_BRANCH_EN only)

module inst_fetch_unit #(
  parameter int                ADDR_W   = 6,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              Reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_code,
  output logic [ADDR_W-1:0] pc_out,
  output logic [5:0]        op_code,
  output logic [4:0]        rs_addr,
  output logic [4:0]        rt_addr,
  output logic [4:0]        rd_addr,
  output logic [4:0]        shamt,
  output logic [5:0]        func,
  output logic [31:0]       imm,
  output logic [25:0]       address,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_target
`ifdef IFU_BRANCH_EN
  ,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [15:0]       br_offset
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] drain_addr_q;
  logic              inst_valid_q;
  logic [31:0]       inst_code_q;
  logic [ADDR_W-1:0] pc_out_q;

  logic              redirect;
  logic [ADDR_W-1:0] target_pc;

  // Redirect request and target. jmp_en wins over a branch in the same cycle.
  // The branch target is computed modulo 2^ADDR_W, so each operand is
  // truncated to ADDR_W bits before the add.
`ifdef IFU_BRANCH_EN
  assign redirect  = jmp_en | br_taken;
  assign target_pc = jmp_en ? jmp_target
                            : br_pc + ADDR_W'(1) + ADDR_W'($signed(br_offset));
`else
  assign redirect  = jmp_en;
  assign target_pc = jmp_target;
`endif

  // Fetch control FSM. A redirect while a read is outstanding moves to DRAIN.
  // DRAIN keeps the abandoned address on the bus until that read is acked.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      inst_valid_q <= 1'b0;
      inst_code_q  <= '0;
      pc_out_q     <= '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (redirect) begin
            pc_q <= target_pc;
            if (!mem_ack) begin
              drain_addr_q <= pc_q;
              state_q      <= DRAIN;
            end
          end else if (mem_ack) begin
            inst_code_q  <= mem_rdata;
            pc_out_q     <= pc_q;
            pc_q         <= pc_q + ADDR_W'(1);
            inst_valid_q <= 1'b1;
            state_q      <= FULL;
          end
        end
        FULL: begin
          if (redirect || inst_ready) begin
            inst_valid_q <= 1'b0;
            state_q      <= FETCH;
            if (redirect) begin
              pc_q <= target_pc;
            end
          end
        end
        DRAIN: begin
          if (redirect) begin
            pc_q <= target_pc;
          end
          if (mem_ack) begin
            state_q <= FETCH;
          end
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

  // The request is gated by Reset so that nothing is issued while Reset is held.
  assign mem_req    = !Reset && ((state_q == FETCH) || (state_q == DRAIN));
  assign mem_addr   = (state_q == DRAIN) ? drain_addr_q : pc_q;

  assign inst_valid = inst_valid_q;
  assign inst_code  = inst_code_q;
  assign pc_out     = pc_out_q;

  // Decode fields taken combinationally from the buffered instruction.
  assign op_code = inst_code_q[31:26];
  assign rs_addr = inst_code_q[25:21];
  assign rt_addr = inst_code_q[20:16];
  assign rd_addr = inst_code_q[15:11];
  assign shamt   = inst_code_q[10:6];
  assign func    = inst_code_q[5:0];
  assign imm     = {{16{inst_code_q[15]}}, inst_code_q[15:0]};
  assign address = inst_code_q[25:0];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit. A behavioural memory responder with a
// programmable ack delay serves the fetch requests. Every accepted memory word
// is pushed onto a scoreboard queue, and the queue is popped when decode takes
// the instruction. The directed steps cover throughput, PC wrap, stalls, jump
// redirects in each state, and reset in DRAIN and FULL. The branch steps run
// only when IFU_BRANCH_EN is defined.

module tb_inst_fetch_unit;

  localparam int                ADDR_W   = 6;
  localparam logic [ADDR_W-1:0] RESET_PC = 6'd0;

  logic              clk;
  logic              Reset = 1'b1;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [31:0]       mem_rdata = '0;
  logic              inst_valid;
  logic              inst_ready = 1'b0;
  logic [31:0]       inst_code;
  logic [ADDR_W-1:0] pc_out;
  logic [5:0]        op_code;
  logic [4:0]        rs_addr;
  logic [4:0]        rt_addr;
  logic [4:0]        rd_addr;
  logic [4:0]        shamt;
  logic [5:0]        func;
  logic [31:0]       imm;
  logic [25:0]       address;
  logic              jmp_en = 1'b0;
  logic [ADDR_W-1:0] jmp_target = '0;
`ifdef IFU_BRANCH_EN
  logic              br_taken = 1'b0;
  logic [ADDR_W-1:0] br_pc = '0;
  logic [15:0]       br_offset = '0;
`endif

  inst_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_code  (inst_code),
    .pc_out     (pc_out),
    .op_code    (op_code),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rd_addr    (rd_addr),
    .shamt      (shamt),
    .func       (func),
    .imm        (imm),
    .address    (address),
    .jmp_en     (jmp_en),
    .jmp_target (jmp_target)
`ifdef IFU_BRANCH_EN
    ,
    .br_taken   (br_taken),
    .br_pc      (br_pc),
    .br_offset  (br_offset)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       code;
  } exp_t;

  exp_t              expQ[$];
  int                assertCount = 0;
  int                failCount = 0;
  int                ackDelay = 0;
  int                reqAge = 0;
  int                deliveredCnt = 0;
  logic              draining = 1'b0;
  logic [ADDR_W-1:0] expAddr = '0;
  logic [ADDR_W-1:0] heldAddr = '0;
`ifdef IFU_BRANCH_EN
  logic              brReq = 1'b0;
  logic [ADDR_W-1:0] brPcV = '0;
  logic [15:0]       brOffV = '0;
`endif

  // Memory contents: the address appears in both the top and bottom fields,
  // and bit 15 is set so that imm sign extension is exercised.
  function automatic logic [31:0] memWord(input logic [ADDR_W-1:0] a);
    return {a, 20'hA5F3C, a};
  endfunction

  // One immediate-assertion comparison.
  task automatic checkOutput(input string tag, input logic [95:0] observed,
                             input logic [95:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of decode/execute inputs and answer memory requests.
  // Accepted memory words go onto the scoreboard. Completed transfers are
  // popped and compared.
  task automatic applyStimulus(input logic ready, input logic jmp,
                               input logic [ADDR_W-1:0] jtarget);
    logic              redirect;
    logic [ADDR_W-1:0] tgt;
    exp_t              e;
    redirect = jmp;
    tgt      = jtarget;
`ifdef IFU_BRANCH_EN
    br_taken  = brReq;
    br_pc     = brPcV;
    br_offset = brOffV;
    if (!jmp && brReq) begin
      redirect = 1'b1;
      tgt = ADDR_W'(int'(brPcV) + 1 + int'($signed(brOffV)));
    end
`endif
    inst_ready = ready;
    jmp_en     = jmp;
    jmp_target = jtarget;

    checkOutput("req_while_valid", {95'b0, mem_req & inst_valid}, 96'd0);

    if (inst_valid === 1'b1 && (ready || redirect)) begin
      assertCount++;
      assert (expQ.size() != 0) else begin
        failCount++;
        $error("[TB] FAIL unexpected_inst: observed pc 0x%0h expected none", pc_out);
      end
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        if (ready) begin
          checkOutput("pc_out", {90'b0, pc_out}, {90'b0, e.pc});
          checkOutput("inst_code", {64'b0, inst_code}, {64'b0, e.code});
          checkOutput("fields",
            {6'b0, op_code, rs_addr, rt_addr, rd_addr, shamt, func, imm, address},
            {6'b0, e.code[31:26], e.code[25:21], e.code[20:16], e.code[15:11],
             e.code[10:6], e.code[5:0], {{16{e.code[15]}}, e.code[15:0]},
             e.code[25:0]});
          deliveredCnt++;
        end
      end
    end

    mem_ack   = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    if (mem_req === 1'b1) begin
      if (reqAge == 0) begin
        checkOutput("req_addr", {90'b0, mem_addr}, {90'b0, expAddr});
        heldAddr = expAddr;
      end else begin
        checkOutput("addr_stable", {90'b0, mem_addr}, {90'b0, heldAddr});
      end
      if (reqAge == ackDelay) begin
        mem_ack   = 1'b1;
        mem_rdata = memWord(heldAddr);
        if (!draining && !redirect) begin
          expQ.push_back({heldAddr, memWord(heldAddr)});
          expAddr = heldAddr + ADDR_W'(1);
        end
        draining = 1'b0;
        reqAge   = 0;
      end else begin
        reqAge++;
        if (redirect) draining = 1'b1;
      end
    end
    if (redirect) expAddr = tgt;
    tick();
  endtask

  // Apply Reset for one edge, check the reset state, then release Reset.
  task automatic doReset();
    Reset      = 1'b1;
    mem_ack    = 1'b0;
    inst_ready = 1'b0;
    jmp_en     = 1'b0;
`ifdef IFU_BRANCH_EN
    br_taken   = 1'b0;
`endif
    tick();
    checkOutput("reset_valid", {95'b0, inst_valid}, 96'd0);
    checkOutput("reset_req", {95'b0, mem_req}, 96'd0);
    checkOutput("reset_code", {64'b0, inst_code}, 96'd0);
    checkOutput("reset_pc_out", {90'b0, pc_out}, 96'd0);
    Reset = 1'b0;
    #1;
    expQ.delete();
    draining = 1'b0;
    reqAge   = 0;
    expAddr  = RESET_PC;
    checkOutput("release_req", {95'b0, mem_req}, 96'd1);
    checkOutput("release_addr", {90'b0, mem_addr}, {90'b0, RESET_PC});
  endtask

  initial begin
    doReset();

    // Zero-wait memory with decode always ready: one instruction every
    // two cycles, with the PC wrapping 63 -> 0.
    ackDelay = 0;
    for (int i = 0; i < 132; i++) applyStimulus(1'b1, 1'b0, '0);
    checkOutput("throughput_count", 96'(deliveredCnt), 96'd66);

    // Ack delayed three cycles, then decode stalled for four cycles.
    ackDelay = 3;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("stall_valid", {95'b0, inst_valid}, 96'd1);
      checkOutput("stall_pc_out", {90'b0, pc_out}, 96'd2);
      checkOutput("stall_code", {64'b0, inst_code}, {64'b0, memWord(6'd2)});
      checkOutput("stall_no_req", {95'b0, mem_req}, 96'd0);
      applyStimulus(1'b0, 1'b0, '0);
    end
    applyStimulus(1'b1, 1'b0, '0);

    // Jump while FULL holds pc_out=5.
    ackDelay = 0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, '0);
    checkOutput("full5_valid", {95'b0, inst_valid}, 96'd1);
    checkOutput("full5_pc_out", {90'b0, pc_out}, 96'd5);
    applyStimulus(1'b0, 1'b1, 6'h20);
    checkOutput("jmp_full_valid", {95'b0, inst_valid}, 96'd0);
    checkOutput("jmp_full_req", {95'b0, mem_req}, 96'd1);
    checkOutput("jmp_full_addr", {90'b0, mem_addr}, 96'h20);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("jmp_full_pc_out", {90'b0, pc_out}, 96'h20);
    applyStimulus(1'b1, 1'b0, '0);

    // Jump in the same cycle as a zero-wait ack: the word is dropped.
    applyStimulus(1'b1, 1'b1, 6'h3F);
    checkOutput("jmp_ack_valid", {95'b0, inst_valid}, 96'd0);
    checkOutput("jmp_ack_addr", {90'b0, mem_addr}, 96'h3F);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);

    // Jump one cycle before a delayed ack: go through DRAIN.
    ackDelay = 3;
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 6'h10);
    checkOutput("drain_valid", {95'b0, inst_valid}, 96'd0);
    checkOutput("drain_addr", {90'b0, mem_addr}, 96'd0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("post_drain_valid", {95'b0, inst_valid}, 96'd0);
    checkOutput("post_drain_addr", {90'b0, mem_addr}, 96'h10);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, '0);

    // Two redirects during DRAIN: the latest target wins.
    applyStimulus(1'b0, 1'b1, 6'h08);
    applyStimulus(1'b0, 1'b1, 6'h2A);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("latest_wins_addr", {90'b0, mem_addr}, 96'h2A);

    // Reset while in DRAIN.
    applyStimulus(1'b0, 1'b1, 6'h05);
    checkOutput("pre_reset_drain_valid", {95'b0, inst_valid}, 96'd0);
    doReset();

    // Reset while in FULL.
    ackDelay = 0;
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("pre_reset_full_valid", {95'b0, inst_valid}, 96'd1);
    doReset();

`ifdef IFU_BRANCH_EN
    // Relative branch: 10 + 1 - 3 = 8.
    applyStimulus(1'b0, 1'b0, '0);
    brReq = 1'b1; brPcV = 6'd10; brOffV = 16'hFFFD;
    applyStimulus(1'b0, 1'b0, '0);
    brReq = 1'b0;
    checkOutput("branch_addr", {90'b0, mem_addr}, 96'd8);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    // Branch and jump in the same cycle: the jump wins.
    applyStimulus(1'b0, 1'b0, '0);
    brReq = 1'b1;
    applyStimulus(1'b0, 1'b1, 6'h30);
    brReq = 1'b0;
    checkOutput("branch_jmp_prio_addr", {90'b0, mem_addr}, 96'h30);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
`endif

    checkOutput("queue_empty", 96'(expQ.size()), 96'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
